clock_set_controller: RTL

Button-sequencing controller for the digital clock's time-set function. Takes three debounced push-button levels (mode, inc, dec) and synchronises and edge-detects them internally. A set-mode FSM (RUN, SET_HR, SET_MIN, SET_SEC) walks through the fields and emits single-cycle inc/dec/clear strobes to the hour/minute/second counters, with hold-to-auto-repeat. It also drives the run-enable and field-blink signals used by the timekeeping and display blocks.

---
 rtl/clock_set_controller.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/clock_set_controller.sv
// Time-set button sequencer for the digital clock.
// Synchronises and edge-detects mode/inc/dec. Walks RUN -> SET_HR -> SET_MIN -> SET_SEC,
// issues single-cycle adjust strobes with hold-to-repeat, and drives run-enable, field
// select and blink for the selected field.
module clock_set_controller #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned REPEAT_DELAY = 50000000,
  parameter int unsigned REPEAT_RATE  = 10000000,
  parameter int unsigned BLINK_HALF   = 25000000,
  parameter int unsigned IDLE_TIMEOUT = 1000000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  output logic       inc_hour,
  output logic       dec_hour,
  output logic       inc_min,
  output logic       dec_min,
  output logic       clr_sec,
  output logic       clock_run,
  output logic [1:0] field_sel,
  output logic       blink
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StSetHr  = 2'd1,
    StSetMin = 2'd2,
    StSetSec = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntOne       = CNT_W'(1);
  localparam logic [CNT_W-1:0] RptDelayLast = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RptRateLast  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] BlinkLast    = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] IdleLast     = CNT_W'(IDLE_TIMEOUT - 1);

  // Button bit positions inside the synchroniser vectors
  localparam int unsigned BtnMode = 0;
  localparam int unsigned BtnInc  = 1;
  localparam int unsigned BtnDec  = 2;

  logic [2:0] btn_raw;
  logic [2:0] s0_q, s1_q, s2_q;
  logic [2:0] btn_rise;

  logic mode_rise, inc_rise, dec_rise;
  logic inc_held, dec_held, both_held, held_dir;

  state_e state_q, state_d;

  logic             armed_q, armed_nxt, armed_d;
  logic             dir_dec_q, dir_dec_nxt, dir_dec_d;
  logic             rpt_phase_q, rpt_phase_nxt, rpt_phase_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_nxt, rpt_cnt_d;
  logic [CNT_W-1:0] rpt_last;

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_q, blink_d;
  logic             timeout;

  logic strobe, strobe_dec;

  logic       inc_hour_q, inc_hour_d;
  logic       dec_hour_q, dec_hour_d;
  logic       inc_min_q, inc_min_d;
  logic       dec_min_q, dec_min_d;
  logic       clr_sec_q, clr_sec_d;
  logic       clock_run_q, clock_run_d;
  logic [1:0] field_sel_q, field_sel_d;

  assign btn_raw = {dec_btn, inc_btn, mode_btn};

  // Two-flop synchroniser plus one history flop per button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s0_q <= btn_raw;
      s1_q <= s0_q;
      s2_q <= s1_q;
    end
  end

  assign btn_rise  = s1_q & ~s2_q;
  assign mode_rise = btn_rise[BtnMode];
  assign inc_rise  = btn_rise[BtnInc];
  assign dec_rise  = btn_rise[BtnDec];
  assign inc_held  = s1_q[BtnInc];
  assign dec_held  = s1_q[BtnDec];
  assign both_held = inc_held & dec_held;

  // Repeat only continues on the button that armed it
  assign held_dir = dir_dec_q ? dec_held : inc_held;
  assign rpt_last = rpt_phase_q ? RptRateLast : RptDelayLast;

  // Strobe generation and hold-to-repeat sequencing
  always_comb begin
    strobe        = 1'b0;
    strobe_dec    = 1'b0;
    armed_nxt     = armed_q;
    dir_dec_nxt   = dir_dec_q;
    rpt_phase_nxt = rpt_phase_q;
    rpt_cnt_nxt   = rpt_cnt_q;
    if (mode_rise || (state_q == StRun) || both_held) begin
      // Mode wins over adjust; chords and RUN disarm until a fresh press
      armed_nxt     = 1'b0;
      rpt_phase_nxt = 1'b0;
      rpt_cnt_nxt   = '0;
    end else if (inc_rise || dec_rise) begin
      strobe        = 1'b1;
      strobe_dec    = dec_rise;
      armed_nxt     = 1'b1;
      dir_dec_nxt   = dec_rise;
      rpt_phase_nxt = 1'b0;
      rpt_cnt_nxt   = '0;
    end else if (armed_q && held_dir) begin
      if (rpt_cnt_q == rpt_last) begin
        strobe        = 1'b1;
        strobe_dec    = dir_dec_q;
        rpt_phase_nxt = 1'b1;
        rpt_cnt_nxt   = '0;
      end else begin
        rpt_cnt_nxt = rpt_cnt_q + CntOne;
      end
    end else begin
      armed_nxt     = 1'b0;
      rpt_phase_nxt = 1'b0;
      rpt_cnt_nxt   = '0;
    end
  end

  // Mode sequencing and idle timeout; timeout also drops any repeat in progress
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    timeout    = 1'b0;
    if (mode_rise) begin
      unique case (state_q)
        StRun:    state_d = StSetHr;
        StSetHr:  state_d = StSetMin;
        StSetMin: state_d = StSetSec;
        StSetSec: state_d = StRun;
        default:  state_d = StRun;
      endcase
      idle_cnt_d = '0;
    end else if (state_q == StRun) begin
      idle_cnt_d = '0;
    end else if (inc_rise || dec_rise || strobe) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == IdleLast) begin
      timeout    = 1'b1;
      state_d    = StRun;
      idle_cnt_d = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + CntOne;
    end

    armed_d     = timeout ? 1'b0 : armed_nxt;
    dir_dec_d   = dir_dec_nxt;
    rpt_phase_d = timeout ? 1'b0 : rpt_phase_nxt;
    rpt_cnt_d   = timeout ? '0 : rpt_cnt_nxt;
  end

  // Blink half-period timer; restarts visible on entry and on every adjust
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if ((state_d == StRun) || (state_d != state_q) || strobe) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CntOne;
    end
  end

  // Output decode from the current field and the next state
  always_comb begin
    inc_hour_d  = strobe & ~strobe_dec & (state_q == StSetHr);
    dec_hour_d  = strobe &  strobe_dec & (state_q == StSetHr);
    inc_min_d   = strobe & ~strobe_dec & (state_q == StSetMin);
    dec_min_d   = strobe &  strobe_dec & (state_q == StSetMin);
    clr_sec_d   = strobe & (state_q == StSetSec);
    clock_run_d = (state_d != StSetSec);
    field_sel_d = 2'd0;
    unique case (state_d)
      StRun:    field_sel_d = 2'd0;
      StSetHr:  field_sel_d = 2'd1;
      StSetMin: field_sel_d = 2'd2;
      StSetSec: field_sel_d = 2'd3;
      default:  field_sel_d = 2'd0;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      armed_q     <= 1'b0;
      dir_dec_q   <= 1'b0;
      rpt_phase_q <= 1'b0;
      rpt_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      inc_hour_q  <= 1'b0;
      dec_hour_q  <= 1'b0;
      inc_min_q   <= 1'b0;
      dec_min_q   <= 1'b0;
      clr_sec_q   <= 1'b0;
      clock_run_q <= 1'b1;
      field_sel_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      dir_dec_q   <= dir_dec_d;
      rpt_phase_q <= rpt_phase_d;
      rpt_cnt_q   <= rpt_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      inc_hour_q  <= inc_hour_d;
      dec_hour_q  <= dec_hour_d;
      inc_min_q   <= inc_min_d;
      dec_min_q   <= dec_min_d;
      clr_sec_q   <= clr_sec_d;
      clock_run_q <= clock_run_d;
      field_sel_q <= field_sel_d;
    end
  end

  assign inc_hour  = inc_hour_q;
  assign dec_hour  = dec_hour_q;
  assign inc_min   = inc_min_q;
  assign dec_min   = dec_min_q;
  assign clr_sec   = clr_sec_q;
  assign clock_run = clock_run_q;
  assign field_sel = field_sel_q;
  assign blink     = blink_q;

endmodule
